// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and FSM state type for the shared-RAM port arbiter.
package mem_port_arbiter_pkg;
  localparam int MEMORY_ADDRESS_BITS = 8;
  localparam int MEMORY_DATA_BITS    = 8;
  localparam int MEM_ARB_PORTS       = 2;

  typedef enum bit [1:0] {ARB_IDLE, ARB_READ, ARB_WRITE, ARB_TURN} arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle: per-port request/write/address/data in, grant/read-return out.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic [MEM_ARB_PORTS-1:0]       req;
  logic [MEM_ARB_PORTS-1:0]       we;
  logic [MEMORY_ADDRESS_BITS-1:0] addr0;
  logic [MEMORY_ADDRESS_BITS-1:0] addr1;
  logic [MEMORY_DATA_BITS-1:0]    wdata0;
  logic [MEMORY_DATA_BITS-1:0]    wdata1;
  logic [MEM_ARB_PORTS-1:0]       gnt;
  logic [MEM_ARB_PORTS-1:0]       rvalid;
  logic [MEMORY_DATA_BITS-1:0]    rdata;
  logic                           busy;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1,
    input  gnt, rvalid, rdata, busy
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1,
    output gnt, rvalid, rdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way winner select; prio_i names the port that wins when both request.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] pick_o
);
  always_comb begin
    // NOTE: default first so every path assigns pick_o and no latch is inferred.
    pick_o = 2'b00;
    case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
      2'b11:   pick_o = prio_i ? 2'b10 : 2'b01;
      default: pick_o = 2'b00;
    endcase
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single shared RAM port. Define MEM_ARB_ROUND_ROBIN_EN
// for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = MEM_ARB_PORTS
) (
  input  logic                           clk,
  input  logic                           reset,
  mem_port_arbiter_if.slave              port_if,
  output logic [MEMORY_ADDRESS_BITS-1:0] ram_address_o,
  inout  wire  [MEMORY_DATA_BITS-1:0]    ram_data_io,
  output logic                           ram_read_en_o,
  output logic                           ram_write_en_o
);
  if (NUM_PORTS != 2) begin : g_bad_ports
    $error("mem_port_arbiter supports exactly 2 ports, got %0d", NUM_PORTS);
  end

  arb_state_t                     state_q;
  logic [1:0]                     gnt_q;
  logic [1:0]                     rvalid_q;
  logic                           owner_q;
  logic [MEMORY_ADDRESS_BITS-1:0] addr_q;
  logic [MEMORY_DATA_BITS-1:0]    wdata_q;
  logic [MEMORY_DATA_BITS-1:0]    rdata_q;
  logic                           re_q;
  logic                           we_q;
  logic                           prio;
  logic [1:0]                     pick;
  logic                           pick_port;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_q;
  assign prio = ptr_q;
`else
  assign prio = 1'b0;
`endif

  rr_pick2 u_pick (
    .req_i  (port_if.req),
    .prio_i (prio),
    .pick_o (pick)
  );

  assign pick_port = pick[1];

  // NOTE: asynchronous reset cuts strobes and releases the bus without waiting for an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      // Grant and read-return are one-cycle pulses unless re-armed below.
      gnt_q    <= '0;
      rvalid_q <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (|pick) begin
            gnt_q   <= pick;
            owner_q <= pick_port;
            addr_q  <= pick_port ? port_if.addr1  : port_if.addr0;
            wdata_q <= pick_port ? port_if.wdata1 : port_if.wdata0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q   <= ~pick_port;
`endif
            if (port_if.we[pick_port]) begin
              we_q    <= 1'b1;
              state_q <= ARB_WRITE;
            end else begin
              re_q    <= 1'b1;
              state_q <= ARB_READ;
            end
          end
        end
        ARB_READ: begin
          rdata_q  <= ram_data_io;
          rvalid_q <= owner_q ? 2'b10 : 2'b01;
          re_q     <= 1'b0;
          state_q  <= ARB_IDLE;
        end
        ARB_WRITE: begin
          we_q    <= 1'b0;
          state_q <= ARB_TURN;
        end
        ARB_TURN: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  assign ram_data_io    = (state_q == ARB_WRITE) ? wdata_q : {MEMORY_DATA_BITS{1'bz}};
  assign ram_address_o  = addr_q;
  assign ram_read_en_o  = re_q;
  assign ram_write_en_o = we_q;

  assign port_if.gnt    = gnt_q;
  assign port_if.rvalid = rvalid_q;
  assign port_if.rdata  = rdata_q;
  assign port_if.busy   = (state_q != ARB_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW    = MEMORY_ADDRESS_BITS;
  localparam int DW    = MEMORY_DATA_BITS;
  localparam int DEPTH = 1 << AW;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if arb_if ();
  logic [AW-1:0] ram_address;
  wire  [DW-1:0] ram_data;
  logic          ram_read_en;
  logic          ram_write_en;

  mem_port_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .port_if        (arb_if),
    .ram_address_o  (ram_address),
    .ram_data_io    (ram_data),
    .ram_read_en_o  (ram_read_en),
    .ram_write_en_o (ram_write_en)
  );

  // RAM: unwritten words hold a fixed pattern; when neither strobe is up the
  // bench pulls the bus to zero, so any stray arbiter drive shows as nonzero.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return DW'(a) ^ DW'(8'hB5);
  endfunction

  logic [DW-1:0]    ram [DEPTH];
  logic [DEPTH-1:0] ram_vld = '0;
  logic [DW-1:0]    ram_rd;
  assign ram_rd   = ram_vld[ram_address] ? ram[ram_address] : init_val(ram_address);
  assign ram_data = ram_write_en ? {DW{1'bz}} : (ram_read_en ? ram_rd : '0);

  always @(posedge clk) begin
    if (ram_write_en) begin
      ram[ram_address]     <= ram_data;
      ram_vld[ram_address] <= 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-edge transaction bookkeeping.
  logic [DW-1:0] shadow [DEPTH];
  int            m_wait;
  int            m_last;
  bit            m_rd_pend;
  int            m_rd_port;
  logic [AW-1:0] m_rd_addr;
  bit            m_wr_pend;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data;
  logic [DW-1:0] m_rdata;
  logic [1:0]    e_gnt, e_rvalid;
  logic          e_re, e_we, e_busy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  task automatic model_reset();
    m_wait = 0; m_last = 1; m_rd_pend = 0; m_wr_pend = 0; m_rdata = '0;
    e_gnt = '0; e_rvalid = '0; e_re = 0; e_we = 0; e_busy = 0; e_addr = '0; e_wdata = '0;
  endtask

  task automatic model_edge();
    int w;
    e_gnt = '0; e_rvalid = '0; e_re = 0; e_we = 0;
    if (m_wr_pend) begin
      shadow[m_wr_addr] = m_wr_data;
      m_wr_pend = 0;
    end
    if (m_rd_pend) begin
      e_rvalid  = 2'(1 << m_rd_port);
      m_rdata   = shadow[m_rd_addr];
      m_rd_pend = 0;
    end
    if (m_wait > 0) begin
      m_wait--;
    end else if (arb_if.req != 2'b00) begin
      if (arb_if.req == 2'b11) w = RR ? 1 - m_last : 0;
      else                     w = arb_if.req[1] ? 1 : 0;
      m_last = w;
      e_gnt  = 2'(1 << w);
      e_addr = (w == 1) ? arb_if.addr1 : arb_if.addr0;
      if (arb_if.we[w]) begin
        e_we = 1; e_wdata = (w == 1) ? arb_if.wdata1 : arb_if.wdata0;
        m_wr_pend = 1; m_wr_addr = e_addr; m_wr_data = e_wdata; m_wait = 2;
      end else begin
        e_re = 1; m_rd_pend = 1; m_rd_port = w; m_rd_addr = e_addr; m_wait = 1;
      end
    end
    e_busy = (m_wait > 0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("gnt",    arb_if.gnt,    e_gnt);
    check("rvalid", arb_if.rvalid, e_rvalid);
    check("rdata",  arb_if.rdata,  m_rdata);
    check("busy",   arb_if.busy,   e_busy);
    check("ram_re", ram_read_en,   e_re);
    check("ram_we", ram_write_en,  e_we);
    if (e_re || e_we) check("ram_address", ram_address, e_addr);
    if (!e_re) check("bus", ram_data, e_we ? e_wdata : '0);
    for (int p = 0; p < 2; p++) if (e_gnt[p]) arb_if.req[p] = 1'b0;
  endtask

  logic [1:0] got [4];
  logic [1:0] want;

  initial begin
    arb_if.req = '0; arb_if.we = '0;
    arb_if.addr0 = '0; arb_if.addr1 = '0; arb_if.wdata0 = '0; arb_if.wdata1 = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(AW'(i));
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",    arb_if.gnt,    0);
    check("rst_rvalid", arb_if.rvalid, 0);
    check("rst_busy",   arb_if.busy,   0);
    check("rst_rdata",  arb_if.rdata,  0);
    check("rst_re",     ram_read_en,   0);
    check("rst_we",     ram_write_en,  0);
    check("rst_addr",   ram_address,   0);
    check("rst_bus",    ram_data,      0);
    @(negedge clk);
    reset = 1'b0;

    // Lone read of the preset word at 0x10.
    arb_if.addr0 = 8'h10; arb_if.we = 2'b00; arb_if.req = 2'b01;
    step();
    check("lr_gnt", arb_if.gnt, 2'b01);
    check("lr_re",  ram_read_en, 1);
    step();
    check("lr_rvalid", arb_if.rvalid, 2'b01);
    check("lr_rdata",  arb_if.rdata,  8'hA5);
    check("lr_re_off", ram_read_en,   0);

    // Lone write from port 1, then read it back.
    arb_if.addr1 = 8'h20; arb_if.wdata1 = 8'h3C; arb_if.we = 2'b10; arb_if.req = 2'b10;
    step();
    check("lw_we",  ram_write_en, 1);
    check("lw_bus", ram_data,     8'h3C);
    step();
    check("lw_we_off",  ram_write_en, 0);
    check("lw_bus_rel", ram_data,     0);
    step();
    arb_if.addr0 = 8'h20; arb_if.we = 2'b00; arb_if.req = 2'b01;
    step();
    step();
    check("lw_readback", arb_if.rdata, 8'h3C);

    // Both ports reading back to back.
    arb_if.addr0 = 8'h01; arb_if.addr1 = 8'h02; arb_if.we = 2'b00; arb_if.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      got[i] = arb_if.gnt;
      arb_if.req = 2'b11;
      step();
    end
    for (int i = 0; i < 4; i++) begin
      want = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
      check("both_seq", got[i], want);
    end
    arb_if.req = 2'b00;
    step();

    // Port 0 requests while port 1 is writing: waits through WRITE and TURN.
    arb_if.addr1 = 8'h30; arb_if.wdata1 = 8'h5A; arb_if.we = 2'b10; arb_if.req = 2'b10;
    step();
    check("wq_gnt1", arb_if.gnt, 2'b10);
    arb_if.addr0 = 8'h30; arb_if.we[0] = 1'b0; arb_if.req[0] = 1'b1;
    step();
    check("wq_turn", arb_if.gnt, 0);
    step();
    check("wq_idle", arb_if.gnt, 0);
    step();
    check("wq_gnt0", arb_if.gnt, 2'b01);
    step();
    check("wq_rdata", arb_if.rdata, 8'h5A);

    // Reset during WRITE with port 0 pending.
    arb_if.addr1 = 8'h40; arb_if.wdata1 = 8'hC3; arb_if.we = 2'b10; arb_if.req = 2'b10;
    step();
    arb_if.addr0 = 8'h10; arb_if.we[0] = 1'b0; arb_if.req[0] = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("rw_we",     ram_write_en,  0);
    check("rw_bus",    ram_data,      0);
    check("rw_busy",   arb_if.busy,   0);
    check("rw_rvalid", arb_if.rvalid, 0);
    check("rw_gnt",    arb_if.gnt,    0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step();
    check("rw_regrant", arb_if.gnt, 2'b01);
    step();
    check("rw_rdata", arb_if.rdata, 8'hA5);
    arb_if.addr0 = 8'h40; arb_if.req = 2'b01;
    step();
    step();
    check("rw_nowrite", arb_if.rdata, 8'hF5);

    // Reset during READ.
    arb_if.addr0 = 8'h50; arb_if.req = 2'b01;
    step();
    #1 reset = 1'b1;
    #1;
    check("rr_rvalid", arb_if.rvalid, 0);
    check("rr_rdata",  arb_if.rdata,  0);
    check("rr_re",     ram_read_en,   0);
    check("rr_busy",   arb_if.busy,   0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    arb_if.req = 2'b00;
    step();
    check("rr_no_rvalid", arb_if.rvalid, 0);
    check("rr_rdata0",    arb_if.rdata,  0);

    // Random traffic; requesters hold req until granted.
    for (int c = 0; c < 500; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!arb_if.req[p] && $urandom_range(0, 99) < 55) begin
          arb_if.we[p] = ($urandom_range(0, 2) == 0);
          if (p == 0) begin
            arb_if.addr0  = AW'($urandom_range(0, 15));
            arb_if.wdata0 = DW'($urandom);
          end else begin
            arb_if.addr1  = AW'($urandom_range(0, 15));
            arb_if.wdata1 = DW'($urandom);
          end
          arb_if.req[p] = 1'b1;
        end
      end
      step();
    end
    arb_if.req = 2'b00;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
